// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// lsu_cpu_if / lsu_mem_if
// CPU-side request/response channel and data-memory bus of the load/store unit.
// Revision: 1.0
// ============================================================================

interface lsu_cpu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );
   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

interface lsu_mem_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_rdata, mem_ready
   );
   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit
// Single-outstanding load/store initiator: aligns, issues, waits, extends.
// Revision: 1.0
// ============================================================================

module load_store_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   lsu_cpu_if.slave   cpu,
   lsu_mem_if.master  mem
);

   localparam int              CW         = $clog2(TIMEOUT);
   localparam logic [CW-1:0]   c_CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        r_state;
   logic          r_req_ready;
   logic          r_resp_valid;
   logic [31:0]   r_resp_rdata;
   logic          r_resp_err;
   logic          r_mem_req;
   logic          r_mem_we;
   logic [31:0]   r_mem_addr;
   logic [3:0]    r_mem_be;
   logic [31:0]   r_mem_wdata;
   logic [1:0]    r_lane;
   logic [2:0]    r_funct3;
   logic [CW-1:0] r_cnt;

   logic          w_accept;
   logic          w_illegal;
   logic          w_misal;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_ext;

   assign w_accept = cpu.req_valid & r_req_ready;

   // Unsigned loads have no store counterpart, so 100/101 are only legal for loads.
   always_comb begin
      w_illegal = 1'b1;
      case (cpu.req_funct3)
         3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
         3'b100, 3'b101:         w_illegal = cpu.req_we;
         default:                w_illegal = 1'b1;
      endcase
   end

   assign w_misal = ((cpu.req_funct3[1:0] == 2'b01) && cpu.req_addr[0]) ||
                    ((cpu.req_funct3[1:0] == 2'b10) && (cpu.req_addr[1:0] != 2'b00));

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = cpu.req_wdata;
      case (cpu.req_funct3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << cpu.req_addr[1:0];
            w_wdata = {4{cpu.req_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = cpu.req_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{cpu.req_wdata[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = cpu.req_wdata;
         end
      endcase
   end

   always_comb begin
      w_byte = mem.mem_rdata[7:0];
      case (r_lane)
         2'd0:    w_byte = mem.mem_rdata[7:0];
         2'd1:    w_byte = mem.mem_rdata[15:8];
         2'd2:    w_byte = mem.mem_rdata[23:16];
         default: w_byte = mem.mem_rdata[31:24];
      endcase
      w_half = r_lane[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
      w_ext  = mem.mem_rdata;
      case (r_funct3)
         3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_ext = {{16{w_half[15]}}, w_half};
         3'b100:  w_ext = {24'd0, w_byte};
         3'b101:  w_ext = {16'd0, w_half};
         default: w_ext = mem.mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'd0;
         r_resp_err   <= 1'b0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= 32'd0;
         r_mem_be     <= 4'd0;
         r_mem_wdata  <= 32'd0;
         r_lane       <= 2'd0;
         r_funct3     <= 3'd0;
         r_cnt        <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_resp_valid <= 1'b0;
               if (w_accept) begin
                  r_lane      <= cpu.req_addr[1:0];
                  r_funct3    <= cpu.req_funct3;
                  r_req_ready <= 1'b0;
                  r_cnt       <= '0;
                  if (w_illegal || w_misal) begin
                     r_state      <= S_DONE;
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= 1'b1;
                     r_resp_rdata <= 32'd0;
                  end else begin
                     r_state     <= S_BUS;
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= cpu.req_we;
                     r_mem_addr  <= {cpu.req_addr[31:2], 2'b00};
                     r_mem_be    <= w_be;
                     r_mem_wdata <= w_wdata;
                  end
               end
            end
            S_BUS: begin
               // A completion on the last counted cycle takes priority over the timeout.
               if (mem.mem_ready) begin
                  r_state      <= S_DONE;
                  r_mem_req    <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= 1'b0;
                  r_resp_rdata <= r_mem_we ? 32'd0 : w_ext;
                  r_cnt        <= '0;
               end else if (r_cnt == c_CNT_LAST) begin
                  r_state      <= S_DONE;
                  r_mem_req    <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= 1'b1;
                  r_resp_rdata <= 32'd0;
                  r_cnt        <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_state      <= S_IDLE;
               r_resp_valid <= 1'b0;
               r_resp_err   <= 1'b0;
               r_resp_rdata <= 32'd0;
               r_req_ready  <= 1'b1;
            end
            default: begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b1;
               r_mem_req   <= 1'b0;
            end
         endcase
      end
   end

   assign cpu.req_ready  = r_req_ready;
   assign cpu.resp_valid = r_resp_valid;
   assign cpu.resp_rdata = r_resp_rdata;
   assign cpu.resp_err   = r_resp_err;
   assign mem.mem_req    = r_mem_req;
   assign mem.mem_we     = r_mem_we;
   assign mem.mem_addr   = r_mem_addr;
   assign mem.mem_be     = r_mem_be;
   assign mem.mem_wdata  = r_mem_wdata;

endmodule

`default_nettype wire
